// File: rtl/mem_bus_arb.sv
// Two-port (instruction/data) arbiter in front of a single-cycle RAM window.
// Round-robin on contention, one-cycle response slot, stall counter and protocol-error flag.
module mem_bus_arb #(
  parameter logic [31:0] MEM_BASE = 32'h0000_0000,
  parameter int unsigned MEM_SIZE = 65536
) (
  input  logic        clk_sys,
  input  logic        rst_sys,
  input  logic        instr_req_i,
  input  logic [31:0] instr_addr_i,
  output logic        instr_gnt_o,
  output logic        instr_rvalid_o,
  output logic [31:0] instr_rdata_o,
  output logic        instr_err_o,
  input  logic        data_req_i,
  input  logic        data_we_i,
  input  logic [3:0]  data_be_i,
  input  logic [31:0] data_addr_i,
  input  logic [31:0] data_wdata_i,
  output logic        data_gnt_o,
  output logic        data_rvalid_o,
  output logic [31:0] data_rdata_o,
  output logic        data_err_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [3:0]  mem_be_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic        mem_rvalid_i,
  input  logic [31:0] mem_rdata_i,
  output logic [31:0] stall_cnt_o,
  output logic        proto_err_o
);

  localparam logic        LP_INSTR = 1'b0;
  localparam logic [32:0] LP_SIZE  = 33'(MEM_SIZE);

  logic        r_last_grant;
  logic        r_pend;
  logic        r_owner;
  logic        r_err;
  logic        r_we;
  logic        r_proto_err;
  logic [31:0] r_stall;

  logic [31:0] w_instr_off;
  logic [31:0] w_data_off;
  logic        w_instr_inr;
  logic        w_data_inr;
  logic        w_instr_gnt;
  logic        w_data_gnt;
  logic        w_contention;
  logic [1:0]  w_stall_inc;
  logic [32:0] w_stall_sum;
  logic        w_rsp_vld;
  logic [31:0] w_rsp_data;

  // Offsets use 32-bit wrap so addresses below MEM_BASE land out of range.
  assign w_instr_off  = instr_addr_i - MEM_BASE;
  assign w_data_off   = data_addr_i - MEM_BASE;
  assign w_instr_inr  = {1'b0, w_instr_off} < LP_SIZE;
  assign w_data_inr   = {1'b0, w_data_off} < LP_SIZE;
  assign w_contention = instr_req_i & data_req_i & ~rst_sys;

  always_comb begin
    w_instr_gnt = 1'b0;
    w_data_gnt  = 1'b0;
    if (!rst_sys) begin
      if (instr_req_i && data_req_i) begin
        if (r_last_grant == LP_INSTR) w_data_gnt = 1'b1;
        else                          w_instr_gnt = 1'b1;
      end else begin
        w_instr_gnt = instr_req_i;
        w_data_gnt  = data_req_i;
      end
    end
  end

  always_comb begin
    mem_req_o   = 1'b0;
    mem_we_o    = 1'b0;
    mem_be_o    = 4'h0;
    mem_addr_o  = 32'h0;
    mem_wdata_o = 32'h0;
    if (w_data_gnt && w_data_inr) begin
      mem_req_o   = 1'b1;
      mem_we_o    = data_we_i;
      mem_be_o    = data_be_i;
      mem_addr_o  = w_data_off & 32'hFFFF_FFFC;
      mem_wdata_o = data_wdata_i;
    end else if (w_instr_gnt && w_instr_inr) begin
      mem_req_o   = 1'b1;
      mem_be_o    = 4'hF;
      mem_addr_o  = w_instr_off & 32'hFFFF_FFFC;
    end
  end

  assign w_stall_inc = {1'b0, instr_req_i & ~w_instr_gnt & ~rst_sys}
                     + {1'b0, data_req_i & ~w_data_gnt & ~rst_sys};
  assign w_stall_sum = {1'b0, r_stall} + {31'h0, w_stall_inc};

  always_ff @(posedge clk_sys) begin
    if (rst_sys) begin
      r_last_grant <= LP_INSTR;
      r_pend       <= 1'b0;
      r_owner      <= 1'b0;
      r_err        <= 1'b0;
      r_we         <= 1'b0;
      r_proto_err  <= 1'b0;
      r_stall      <= 32'h0;
    end else begin
      r_pend  <= w_instr_gnt | w_data_gnt;
      r_owner <= w_data_gnt;
      r_err   <= w_data_gnt ? ~w_data_inr : (w_instr_gnt & ~w_instr_inr);
      r_we    <= w_data_gnt & data_we_i;
      if (w_contention) r_last_grant <= w_data_gnt;
      if (mem_rvalid_i && (!r_pend || r_err)) r_proto_err <= 1'b1;
      r_stall <= w_stall_sum[32] ? 32'hFFFF_FFFF : w_stall_sum[31:0];
    end
  end

  // Write responses and error responses carry no data.
  assign w_rsp_vld  = r_pend & ~rst_sys;
  assign w_rsp_data = (r_err || r_we) ? 32'h0 : mem_rdata_i;

  assign instr_gnt_o    = w_instr_gnt;
  assign data_gnt_o     = w_data_gnt;
  assign instr_rvalid_o = w_rsp_vld & ~r_owner;
  assign data_rvalid_o  = w_rsp_vld & r_owner;
  assign instr_err_o    = instr_rvalid_o & r_err;
  assign data_err_o     = data_rvalid_o & r_err;
  assign instr_rdata_o  = instr_rvalid_o ? w_rsp_data : 32'h0;
  assign data_rdata_o   = data_rvalid_o ? w_rsp_data : 32'h0;
  assign stall_cnt_o    = r_stall;
  assign proto_err_o    = r_proto_err;

endmodule

// File: tb/tb_mem_bus_arb.sv
// Bench for mem_bus_arb: directed vector table, hand-written corner sequences,
// then random traffic against a transaction-level model with a shadow RAM.
module tb_mem_bus_arb;
  localparam logic [31:0] MEM_BASE = 32'h0000_0000;
  localparam int unsigned MEM_SIZE = 65536;

  logic        clk_sys = 1'b0;
  logic        rst_sys;
  logic        instr_req_i;
  logic [31:0] instr_addr_i;
  logic        instr_gnt_o, instr_rvalid_o, instr_err_o;
  logic [31:0] instr_rdata_o;
  logic        data_req_i, data_we_i;
  logic [3:0]  data_be_i;
  logic [31:0] data_addr_i, data_wdata_i;
  logic        data_gnt_o, data_rvalid_o, data_err_o;
  logic [31:0] data_rdata_o;
  logic        mem_req_o, mem_we_o;
  logic [3:0]  mem_be_o;
  logic [31:0] mem_addr_o, mem_wdata_o;
  logic        mem_rvalid_i;
  logic [31:0] mem_rdata_i = 32'h0;
  logic [31:0] stall_cnt_o;
  logic        proto_err_o;

  int checks = 0;
  int errors = 0;

  always #5 clk_sys = ~clk_sys;

  mem_bus_arb #(.MEM_BASE(MEM_BASE), .MEM_SIZE(MEM_SIZE)) dut (
    .clk_sys(clk_sys), .rst_sys(rst_sys),
    .instr_req_i(instr_req_i), .instr_addr_i(instr_addr_i), .instr_gnt_o(instr_gnt_o),
    .instr_rvalid_o(instr_rvalid_o), .instr_rdata_o(instr_rdata_o), .instr_err_o(instr_err_o),
    .data_req_i(data_req_i), .data_we_i(data_we_i), .data_be_i(data_be_i),
    .data_addr_i(data_addr_i), .data_wdata_i(data_wdata_i), .data_gnt_o(data_gnt_o),
    .data_rvalid_o(data_rvalid_o), .data_rdata_o(data_rdata_o), .data_err_o(data_err_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_be_o(mem_be_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i),
    .stall_cnt_o(stall_cnt_o), .proto_err_o(proto_err_o)
  );

  // RAM environment: one-cycle latency, garbage on rdata when it carries no read data.
  logic [31:0] ram [0:16383];
  logic [31:0] shadow [0:16383];
  logic        ram_rvalid = 1'b0;
  logic        inject = 1'b0;
  assign mem_rvalid_i = ram_rvalid | inject;

  always @(posedge clk_sys) begin
    ram_rvalid <= mem_req_o;
    if (mem_req_o) begin
      if (mem_we_o) begin
        for (int b = 0; b < 4; b++)
          if (mem_be_o[b]) ram[mem_addr_o[15:2]][b*8 +: 8] <= mem_wdata_o[b*8 +: 8];
        mem_rdata_i <= 32'hA5A5_A5A5;
      end else begin
        mem_rdata_i <= ram[mem_addr_o[15:2]];
      end
    end else begin
      mem_rdata_i <= 32'h5A5A_5A5A;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic set_in(input logic ireq, input logic [31:0] iaddr, input logic dreq,
                        input logic dwe, input logic [3:0] dbe, input logic [31:0] daddr,
                        input logic [31:0] dwdata);
    instr_req_i = ireq; instr_addr_i = iaddr;
    data_req_i = dreq; data_we_i = dwe; data_be_i = dbe;
    data_addr_i = daddr; data_wdata_i = dwdata;
  endtask

  task automatic idle();
    set_in(1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
  endtask

  task automatic do_reset();
    @(negedge clk_sys);
    rst_sys = 1'b1; inject = 1'b0; idle();
    repeat (2) @(posedge clk_sys);
    @(negedge clk_sys);
    rst_sys = 1'b0;
  endtask

  typedef struct {
    logic        ireq;  logic [31:0] iaddr;
    logic        dreq;  logic dwe; logic [3:0] dbe; logic [31:0] daddr; logic [31:0] dwdata;
    logic        igt;   logic dgt; logic mreq; logic mwe; logic [3:0] mbe;
    logic [31:0] maddr; logic [31:0] mwdata;
    logic        irv;   logic drv; logic rerr; logic [31:0] rdata;
  } vec_t;

  vec_t tbl [11];

  function automatic logic in_range(input logic [31:0] a);
    logic [31:0] off;
    off = a - MEM_BASE;
    return longint'(off) < longint'(MEM_SIZE);
  endfunction

  function automatic logic [31:0] pick_addr();
    case ($urandom_range(0, 7))
      0:       return 32'h0001_0000 + 32'($urandom_range(0, 255));
      1:       return 32'hFFFF_FF00 | 32'($urandom_range(0, 255));
      default: return 32'($urandom_range(0, 1023));
    endcase
  endfunction

  initial begin
    for (int i = 0; i < 16384; i++) ram[i] = 32'h0;
    ram[32] = 32'h0000_0013;
    rst_sys = 1'b1;
    idle();

    // Reset state with requests pending on both ports.
    @(negedge clk_sys);
    set_in(1'b1, 32'h80, 1'b1, 1'b0, 4'hF, 32'h100, 32'h0);
    #1;
    chk("rst_gnt", {30'h0, instr_gnt_o, data_gnt_o}, 32'h0);
    chk("rst_memreq", {31'h0, mem_req_o}, 32'h0);
    @(negedge clk_sys);
    #1;
    chk("rst_stall", stall_cnt_o, 32'h0);
    chk("rst_proto", {31'h0, proto_err_o}, 32'h0);
    chk("rst_rvalid", {30'h0, instr_rvalid_o, data_rvalid_o}, 32'h0);
    do_reset();

    //        ireq  iaddr        dreq dwe  dbe   daddr         dwdata         igt  dgt  mreq mwe  mbe   maddr      mwdata         irv  drv  err  rdata
    tbl[0]  = '{1'b1, 32'h80,       1'b0, 1'b0, 4'h0, 32'h0,       32'h0,         1'b1, 1'b0, 1'b1, 1'b0, 4'hF, 32'h80,  32'h0,         1'b1, 1'b0, 1'b0, 32'h13};
    tbl[1]  = '{1'b0, 32'h0,        1'b1, 1'b1, 4'h3, 32'h100,     32'hDEADBEEF,  1'b0, 1'b1, 1'b1, 1'b1, 4'h3, 32'h100, 32'hDEADBEEF,  1'b0, 1'b1, 1'b0, 32'h0};
    tbl[2]  = '{1'b0, 32'h0,        1'b1, 1'b0, 4'hF, 32'h100,     32'h0,         1'b0, 1'b1, 1'b1, 1'b0, 4'hF, 32'h100, 32'h0,         1'b0, 1'b1, 1'b0, 32'h0000BEEF};
    tbl[3]  = '{1'b0, 32'h0,        1'b1, 1'b0, 4'hF, 32'h10000,   32'h0,         1'b0, 1'b1, 1'b0, 1'b0, 4'h0, 32'h0,   32'h0,         1'b0, 1'b1, 1'b1, 32'h0};
    tbl[4]  = '{1'b1, 32'h103,      1'b0, 1'b0, 4'h0, 32'h0,       32'h0,         1'b1, 1'b0, 1'b1, 1'b0, 4'hF, 32'h100, 32'h0,         1'b1, 1'b0, 1'b0, 32'h0000BEEF};
    tbl[5]  = '{1'b1, 32'hFFFFFFFC, 1'b0, 1'b0, 4'h0, 32'h0,       32'h0,         1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0,   32'h0,         1'b1, 1'b0, 1'b1, 32'h0};
    tbl[6]  = '{1'b0, 32'h0,        1'b1, 1'b0, 4'h5, 32'h80,      32'h12345678,  1'b0, 1'b1, 1'b1, 1'b0, 4'h5, 32'h80,  32'h12345678,  1'b0, 1'b1, 1'b0, 32'h13};
    tbl[7]  = '{1'b0, 32'h0,        1'b0, 1'b0, 4'h0, 32'h0,       32'h0,         1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0,   32'h0,         1'b0, 1'b0, 1'b0, 32'h0};
    tbl[8]  = '{1'b1, 32'h80,       1'b1, 1'b0, 4'hF, 32'h100,     32'h0,         1'b0, 1'b1, 1'b1, 1'b0, 4'hF, 32'h100, 32'h0,         1'b0, 1'b1, 1'b0, 32'h0000BEEF};
    tbl[9]  = '{1'b1, 32'h80,       1'b1, 1'b0, 4'hF, 32'h100,     32'h0,         1'b1, 1'b0, 1'b1, 1'b0, 4'hF, 32'h80,  32'h0,         1'b1, 1'b0, 1'b0, 32'h13};
    tbl[10] = '{1'b0, 32'h0,        1'b1, 1'b1, 4'hF, 32'h10004,   32'h1,         1'b0, 1'b1, 1'b0, 1'b0, 4'h0, 32'h0,   32'h0,         1'b0, 1'b1, 1'b1, 32'h0};

    for (int i = 0; i < 11; i++) begin
      @(negedge clk_sys);
      set_in(tbl[i].ireq, tbl[i].iaddr, tbl[i].dreq, tbl[i].dwe, tbl[i].dbe, tbl[i].daddr, tbl[i].dwdata);
      #1;
      chk($sformatf("v%0d_gnt", i), {30'h0, instr_gnt_o, data_gnt_o}, {30'h0, tbl[i].igt, tbl[i].dgt});
      chk($sformatf("v%0d_memctl", i), {26'h0, mem_req_o, mem_we_o, mem_be_o},
          {26'h0, tbl[i].mreq, tbl[i].mwe, tbl[i].mbe});
      chk($sformatf("v%0d_maddr", i), mem_addr_o, tbl[i].maddr);
      chk($sformatf("v%0d_mwdata", i), mem_wdata_o, tbl[i].mwdata);
      @(negedge clk_sys);
      idle();
      #1;
      chk($sformatf("v%0d_rsp", i), {28'h0, instr_rvalid_o, instr_err_o, data_rvalid_o, data_err_o},
          {28'h0, tbl[i].irv, tbl[i].irv & tbl[i].rerr, tbl[i].drv, tbl[i].drv & tbl[i].rerr});
      chk($sformatf("v%0d_irdata", i), instr_rdata_o, tbl[i].irv ? tbl[i].rdata : 32'h0);
      chk($sformatf("v%0d_drdata", i), data_rdata_o, tbl[i].drv ? tbl[i].rdata : 32'h0);
    end
    chk("tbl_stall", stall_cnt_o, 32'd2);
    chk("tbl_proto", {31'h0, proto_err_o}, 32'h0);

    // Continuous contention: data, instr, data, instr with pipelined responses.
    do_reset();
    for (int c = 0; c < 5; c++) begin
      @(negedge clk_sys);
      if (c < 4) set_in(1'b1, 32'h80, 1'b1, 1'b0, 4'hF, 32'h84, 32'h0);
      else idle();
      #1;
      if (c < 4)
        chk($sformatf("rr%0d_gnt", c), {30'h0, instr_gnt_o, data_gnt_o},
            (c % 2 == 0) ? 32'h1 : 32'h2);
      if (c > 0)
        chk($sformatf("rr%0d_rvalid", c), {30'h0, instr_rvalid_o, data_rvalid_o},
            (c % 2 == 1) ? 32'h1 : 32'h2);
    end
    chk("rr_stall", stall_cnt_o, 32'd4);

    // Reset lands on the response cycle of an instruction grant.
    do_reset();
    @(negedge clk_sys);
    set_in(1'b1, 32'h80, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    #1;
    chk("rstpend_gnt", {31'h0, instr_gnt_o}, 32'h1);
    @(negedge clk_sys);
    rst_sys = 1'b1;
    set_in(1'b1, 32'h80, 1'b1, 1'b0, 4'hF, 32'h80, 32'h0);
    #1;
    chk("rstpend_out", {26'h0, instr_gnt_o, data_gnt_o, instr_rvalid_o, data_rvalid_o,
                        instr_err_o | data_err_o, mem_req_o}, 32'h0);
    @(negedge clk_sys);
    rst_sys = 1'b0;
    idle();
    #1;
    chk("rstpend_rvalid", {30'h0, instr_rvalid_o, data_rvalid_o}, 32'h0);
    chk("rstpend_stall", stall_cnt_o, 32'h0);

    // Unexpected mem_rvalid_i with nothing pending.
    @(negedge clk_sys);
    inject = 1'b1;
    @(negedge clk_sys);
    inject = 1'b0;
    #1;
    chk("proto_set", {31'h0, proto_err_o}, 32'h1);
    chk("proto_norvalid", {30'h0, instr_rvalid_o, data_rvalid_o}, 32'h0);
    repeat (3) @(negedge clk_sys);
    #1;
    chk("proto_sticky", {31'h0, proto_err_o}, 32'h1);
    do_reset();
    #1;
    chk("proto_clr", {31'h0, proto_err_o}, 32'h0);

    // mem_rvalid_i while the pending response is an error.
    @(negedge clk_sys);
    set_in(1'b0, 32'h0, 1'b1, 1'b0, 4'hF, 32'h10000, 32'h0);
    @(negedge clk_sys);
    idle();
    inject = 1'b1;
    #1;
    chk("errpend_rsp", {29'h0, data_rvalid_o, data_err_o, instr_rvalid_o}, 32'h6);
    chk("errpend_rdata", data_rdata_o, 32'h0);
    @(negedge clk_sys);
    inject = 1'b0;
    #1;
    chk("errpend_proto", {31'h0, proto_err_o}, 32'h1);

    // Random traffic against a transaction-level model.
    do_reset();
    for (int i = 0; i < 16384; i++) shadow[i] = ram[i];
    begin
      int          last_win;   // 0 instr, 1 data: port granted at last contention
      longint      m_stall;
      logic        pv, pport, perr;
      logic [31:0] prdata;
      last_win = 0; m_stall = 0; pv = 0; pport = 0; perr = 0; prdata = 0;
      for (int cyc = 0; cyc < 400; cyc++) begin
        logic        ir, dr, dw, gi, gd, inr;
        logic [3:0]  be;
        logic [31:0] ia, da, wd, a, off;
        logic [31:0] e_addr, e_wd;
        logic [3:0]  e_be;
        logic        e_req, e_we;
        ir = 1'($urandom_range(0, 1)); dr = 1'($urandom_range(0, 1));
        dw = 1'($urandom_range(0, 1)); be = 4'($urandom_range(0, 15));
        ia = pick_addr(); da = pick_addr(); wd = $urandom;
        @(negedge clk_sys);
        set_in(ir, ia, dr, dw, be, da, wd);
        #1;
        chk("rnd_irsp", {30'h0, instr_rvalid_o, instr_err_o}, {30'h0, pv & ~pport, pv & ~pport & perr});
        chk("rnd_drsp", {30'h0, data_rvalid_o, data_err_o}, {30'h0, pv & pport, pv & pport & perr});
        chk("rnd_irdata", instr_rdata_o, (pv && !pport) ? prdata : 32'h0);
        chk("rnd_drdata", data_rdata_o, (pv && pport) ? prdata : 32'h0);
        chk("rnd_stall", stall_cnt_o, 32'(m_stall));
        chk("rnd_proto", {31'h0, proto_err_o}, 32'h0);
        gi = 0; gd = 0;
        if (ir && dr) begin
          if (last_win == 0) gd = 1; else gi = 1;
          last_win = gd ? 1 : 0;
        end else begin
          gi = ir; gd = dr;
        end
        m_stall += (ir && !gi) ? 1 : 0;
        m_stall += (dr && !gd) ? 1 : 0;
        chk("rnd_gnt", {30'h0, instr_gnt_o, data_gnt_o}, {30'h0, gi, gd});
        a = gd ? da : ia;
        inr = in_range(a);
        off = a - MEM_BASE;
        e_req = (gi || gd) && inr;
        e_we = e_req && gd && dw;
        e_be = !e_req ? 4'h0 : (gd ? be : 4'hF);
        e_addr = e_req ? (off / 4) * 4 : 32'h0;
        e_wd = (e_req && gd) ? wd : 32'h0;
        chk("rnd_memctl", {26'h0, mem_req_o, mem_we_o, mem_be_o}, {26'h0, e_req, e_we, e_be});
        chk("rnd_maddr", mem_addr_o, e_addr);
        chk("rnd_mwdata", mem_wdata_o, e_wd);
        pv = gi || gd; pport = gd; perr = pv && !inr;
        prdata = 32'h0;
        if (e_req && !e_we) prdata = shadow[off / 4];
        if (e_we)
          for (int b = 0; b < 4; b++)
            if (be[b]) shadow[off / 4][b*8 +: 8] = wd[b*8 +: 8];
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/mem_bus_arb.md
MEM_BUS_ARB -- requirements
Module: mem_bus_arb

Interface
REQ-001 SHALL have parameter MEM_BASE, default 32'h0000_0000, byte base address of RAM window.
REQ-002 SHALL have parameter MEM_SIZE, default 65536, RAM window size in bytes (power of two, >=8).
REQ-003 SHALL have ports clk_sys in 1 system clock; rst_sys in 1 reset. One clock; reset is synchronous and active-high.
REQ-004 SHALL have instruction port: instr_req_i in 1; instr_addr_i in 32; instr_gnt_o out 1; instr_rvalid_o out 1; instr_rdata_o out 32; instr_err_o out 1.
REQ-005 SHALL have data port: data_req_i in 1; data_we_i in 1; data_be_i in 4; data_addr_i in 32; data_wdata_i in 32; data_gnt_o out 1; data_rvalid_o out 1; data_rdata_o out 32; data_err_o out 1.
REQ-006 SHALL have RAM port: mem_req_o out 1; mem_we_o out 1; mem_be_o out 4; mem_addr_o out 32 (byte offset from MEM_BASE); mem_wdata_o out 32; mem_rvalid_i in 1; mem_rdata_i in 32.
REQ-007 SHALL have status: stall_cnt_o out 32, cycles a requester was refused grant; proto_err_o out 1, sticky unexpected-mem_rvalid_i flag.

Function
REQ-008 SHALL grant at most one request per cycle; gnt combinational in the cycle req is high and the port wins.
REQ-009 Single requester SHALL always be granted the same cycle.
REQ-010 Both requesting SHALL use round-robin: winner = port not granted at last contention; last_grant_q updates only on contention cycles.
REQ-011 In-range = (addr - MEM_BASE) < MEM_SIZE, 32-bit unsigned wrap subtraction.
REQ-012 Granted in-range request SHALL drive mem_req_o=1, mem_addr_o={offset[31:2],2'b00}; data port passes we/be/wdata; instruction port drives we=0, be=4'hF, wdata=0.
REQ-013 Granted out-of-range request SHALL not assert mem_req_o; accepted, answered with error.
REQ-014 No grant SHALL give mem_req_o=0 and mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o all 0.
REQ-015 Each grant SHALL load response slot: pend_q=1, owner_q (0 instr, 1 data), err_q (1 if out of range); no grant clears pend_q.
REQ-016 Response SHALL be exactly one cycle after grant: owner's rvalid_o=1 when pend_q=1; rdata_o=mem_rdata_i if err_q=0, else 32'h0 with err_o=1.
REQ-017 Writes SHALL also get one rvalid (rdata don't-care, driven 32'h0).
REQ-018 Non-owner rvalid_o/err_o SHALL be 0; rdata_o SHALL be 32'h0 whenever its rvalid_o=0.
REQ-019 Back-to-back grants SHALL pipeline: grant N+1 same cycle as response N, full throughput.
REQ-020 mem_rvalid_i high with pend_q=0 or err_q=1 SHALL set proto_err_o until reset; data discarded, no rvalid.
REQ-021 stall_cnt_o SHALL increment by 1 each cycle with req high and no gnt, per port (max 2/cycle), saturating at 32'hFFFF_FFFF.

Reset
REQ-022 rst_sys high at clock edge SHALL clear pend_q, owner_q, err_q, proto_err_o, stall_cnt_o, set last_grant_q=instr (first contention goes to data).
REQ-023 During reset all gnt, rvalid, err, mem_req_o outputs SHALL be 0 regardless of request inputs.
REQ-024 Reset with response pending SHALL drop it: no rvalid in the cycle after reset deasserts.

Verification
REQ-025 Instr-only fetch addr 0x80, RAM word 0x0000_0013 -> instr_gnt_o same cycle, mem_addr_o=0x80, instr_rvalid_o next cycle with rdata 0x0000_0013, err 0.
REQ-026 Both req continuously 4 cycles after reset -> grants data,instr,data,instr; stall_cnt_o=4 at end.
REQ-027 Data write addr 0x100, be=4'b0011, wdata 0xDEAD_BEEF -> mem_we_o=1, mem_be_o=0x3, data_rvalid_o next cycle, later read of 0x100 returns 0x0000_BEEF (RAM zeroed).
REQ-028 Data read addr MEM_BASE+MEM_SIZE (0x10000) -> gnt, mem_req_o=0, next cycle data_rvalid_o=1, data_err_o=1, rdata 0.
REQ-029 Inject mem_rvalid_i with no pending grant -> proto_err_o=1 next cycle, stays 1 until rst_sys.
REQ-030 Assert rst_sys the cycle after an instr grant -> no instr_rvalid_o, all outputs 0, stall_cnt_o=0.
